// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets four requesters share one UART transmitter.
// Latches the winner's byte and frame config, strobes the transmitter and reports completion.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] data,
  input  logic [15:0] cfg,
  input  logic        tx_available,
  output logic [3:0]  ack,
  output logic [1:0]  grant_id,
  output logic        busy,
  output logic        err,
  output logic        tx_flag,
  output logic [7:0]  tx_data,
  output logic        tx_d_num,
  output logic        tx_s_num,
  output logic [1:0]  tx_par
);

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DONE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  ack_q, ack_d;
  logic [1:0]  grant_q, grant_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        flag_q, flag_d;
  logic [7:0]  data_q, data_d;
  logic        dnum_q, dnum_d;
  logic        snum_q, snum_d;
  logic [1:0]  par_q, par_d;

  logic [1:0]  winner;
  logic        found;

  // Search starts just after the last grant; k=4 wraps back to the last grant itself.
  always_comb begin
    winner = last_q;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!found && req[last_q + 2'(k)]) begin
        winner = last_q + 2'(k);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    ack_d   = 4'b0000;
    err_d   = 1'b0;
    grant_d = grant_q;
    flag_d  = flag_q;
    data_d  = data_q;
    dnum_d  = dnum_q;
    snum_d  = snum_q;
    par_d   = par_q;

    unique case (state_q)
      IDLE: begin
        flag_d = 1'b0;
        if (tx_available && found) begin
          data_d                  = data[{winner, 3'b000} +: 8];
          {dnum_d, snum_d, par_d} = cfg[{winner, 2'b00} +: 4];
          grant_d                 = winner;
          last_d                  = winner;
          flag_d                  = 1'b1;
          cnt_d                   = 8'd0;
          state_d                 = LAUNCH;
        end
      end
      LAUNCH: begin
        if (!tx_available) begin
          flag_d  = 1'b0;
          state_d = BUSY;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          // Transmitter never took the strobe: give up without acknowledging.
          flag_d  = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      BUSY: begin
        flag_d = 1'b0;
        if (tx_available) begin
          ack_d   = 4'b0001 << grant_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 2'd3;
      cnt_q   <= 8'd0;
      ack_q   <= 4'b0000;
      grant_q <= 2'd0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      flag_q  <= 1'b0;
      data_q  <= 8'h00;
      dnum_q  <= 1'b1;
      snum_q  <= 1'b1;
      par_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      flag_q  <= flag_d;
      data_q  <= data_d;
      dnum_q  <= dnum_d;
      snum_q  <= snum_d;
      par_q   <= par_d;
    end
  end

  assign ack      = ack_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign tx_flag  = flag_q;
  assign tx_data  = data_q;
  assign tx_d_num = dnum_q;
  assign tx_s_num = snum_q;
  assign tx_par   = par_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a frame-level reference model checked every cycle,
// directed scenarios pinned to hand-computed values, then randomized traffic.
module tb_uart_tx_arbiter;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic [15:0] cfg;
  logic        txAv;
  logic [3:0]  ack;
  logic [1:0]  grantId;
  logic        busy, err, txFlag, txDNum, txSNum;
  logic [7:0]  txData;
  logic [1:0]  txPar;

  int compared = 0;
  int mismatched = 0;

  uart_tx_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .cfg(cfg),
    .tx_available(txAv), .ack(ack), .grant_id(grantId), .busy(busy),
    .err(err), .tx_flag(txFlag), .tx_data(txData), .tx_d_num(txDNum),
    .tx_s_num(txSNum), .tx_par(txPar)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] q, input logic [31:0] d,
                               input logic [15:0] c, input logic av);
    @(negedge clk);
    rst = r; req = q; data = d; cfg = c; txAv = av;
  endtask

  // Reference model: tracks which requester owns the line and how far its frame has got.
  localparam int FREE = 0, STROBING = 1, SENDING = 2, FINISHING = 3;
  int          phase, lastWinner, strobeAge;
  bit          modelValid = 0;
  logic [3:0]  eAck;
  logic [1:0]  eGrant, ePar;
  logic        eBusy, eErr, eFlag, eD, eS;
  logic [7:0]  eData;

  function automatic int pickNext(input int last, input logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  initial forever begin
    int w;
    @(posedge clk);
    if (!rst) begin
      modelValid = 1; phase = FREE; lastWinner = 3; strobeAge = 0;
      eAck = 0; eErr = 0; eBusy = 0; eGrant = 0; eFlag = 0;
      eData = 0; eD = 1; eS = 1; ePar = 0;
    end else if (modelValid) begin
      eAck = 0; eErr = 0;
      if (phase == FINISHING) phase = FREE;
      else if (phase == SENDING) begin
        if (txAv) begin eAck = 4'b0001 << eGrant; phase = FINISHING; end
      end else if (phase == STROBING) begin
        strobeAge++;
        if (!txAv) begin eFlag = 0; phase = SENDING; end
        else if (strobeAge >= TIMEOUT) begin eFlag = 0; eErr = 1; phase = FREE; end
      end else begin
        w = pickNext(lastWinner, req);
        eFlag = 0;
        if (txAv && w >= 0) begin
          lastWinner = w; eGrant = 2'(w); eData = data[8*w +: 8];
          {eD, eS, ePar} = cfg[4*w +: 4];
          eFlag = 1; strobeAge = 0; phase = STROBING;
        end
      end
      eBusy = (phase != FREE);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (modelValid) begin
      checkOutput("ack", 32'(ack), 32'(eAck));
      checkOutput("grant_id", 32'(grantId), 32'(eGrant));
      checkOutput("busy", 32'(busy), 32'(eBusy));
      checkOutput("err", 32'(err), 32'(eErr));
      checkOutput("tx_flag", 32'(txFlag), 32'(eFlag));
      checkOutput("tx_data", 32'(txData), 32'(eData));
      checkOutput("tx_cfg", 32'({txDNum, txSNum, txPar}), 32'({eD, eS, ePar}));
      checkOutput("ack_onehot", 32'($countones(ack) <= 1 && !(err && ack != 0)), 32'd1);
    end
  end

  initial begin
    int n, hold, nAcks;
    int order[5];
    bit sawAck;
    rst = 0; req = 0; data = 0; cfg = 0; txAv = 1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outputs", 32'({ack, grantId, busy, err, txFlag, txData, txDNum, txSNum, txPar}),
                32'({4'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'b00}));

    // Single requester 2 with byte 0xA5 and config 1110.
    applyStimulus(1, 4'b0100, 32'h00A5_0000, 16'h0E00, 1);
    @(posedge clk); #1;
    checkOutput("r2_launch", 32'({txFlag, txData, txDNum, txSNum, txPar, grantId, busy}),
                32'({1'b1, 8'hA5, 1'b1, 1'b1, 2'b10, 2'd2, 1'b1}));
    applyStimulus(1, 4'b0000, 32'h0, 16'h0, 0);
    @(posedge clk); #1;
    checkOutput("r2_busy", 32'({txFlag, ack, txData}), 32'({1'b0, 4'b0000, 8'hA5}));
    applyStimulus(1, 4'b0000, 32'h0, 16'h0, 1);
    @(posedge clk); #1;
    checkOutput("r2_ack", 32'(ack), 32'(4'b0100));
    @(posedge clk); #1;
    checkOutput("r2_ack_gone", 32'({ack, busy}), 32'({4'b0000, 1'b0}));

    // Requester 1 with the transmitter never accepting: err after TIMEOUT cycles.
    applyStimulus(1, 4'b0010, 32'h0000_3C00, 16'h0050, 1);
    @(posedge clk); #1;
    checkOutput("r1_grant", 32'({txFlag, grantId}), 32'({1'b1, 2'd1}));
    @(negedge clk); req = 0;
    n = 0; sawAck = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(posedge clk); #1;
      if (ack != 0) sawAck = 1;
      if (err) n = i;
    end
    checkOutput("timeout_cycles", 32'(n), 32'(TIMEOUT));
    checkOutput("timeout_no_ack", 32'(sawAck), 32'd0);
    @(posedge clk); #1;
    checkOutput("timeout_after", 32'({txFlag, err, busy}), 32'd0);

    // Reset while requester 0's frame is on the line.
    applyStimulus(1, 4'b0001, 32'h0000_0077, 16'h000B, 1);
    @(posedge clk); #1;
    checkOutput("r0_grant", 32'({txFlag, grantId, txData}), 32'({1'b1, 2'd0, 8'h77}));
    applyStimulus(1, 4'b0000, 32'h0, 16'h0, 0);
    applyStimulus(0, 4'b0000, 32'h0, 16'h0, 0);
    @(posedge clk); #1;
    checkOutput("midframe_reset", 32'({ack, grantId, busy, err, txFlag, txData, txDNum, txSNum, txPar}),
                32'({4'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'b00}));
    applyStimulus(1, 4'b0000, 32'h0, 16'h0, 1);
    sawAck = 0;
    repeat (6) begin @(posedge clk); #1; if (ack != 0) sawAck = 1; end
    checkOutput("abandoned_no_ack", 32'(sawAck), 32'd0);

    // All four requesting continuously, transmitter busy for two cycles per frame.
    applyStimulus(1, 4'b1111, 32'h4433_2211, 16'h1234, 1);
    hold = 0; nAcks = 0;
    for (int i = 0; i < 5; i++) order[i] = -1;
    for (int c = 0; c < 300 && nAcks < 5; c++) begin
      @(posedge clk); #1;
      for (int b = 0; b < 4; b++) if (ack[b]) begin order[nAcks] = b; nAcks++; end
      @(negedge clk);
      if (txFlag) begin txAv = 0; hold = 2; end
      else if (hold > 0) begin hold--; if (hold == 0) txAv = 1; end
    end
    checkOutput("rr_order0", 32'(order[0]), 32'd0);
    checkOutput("rr_order1", 32'(order[1]), 32'd1);
    checkOutput("rr_order2", 32'(order[2]), 32'd2);
    checkOutput("rr_order3", 32'(order[3]), 32'd3);
    checkOutput("rr_order4", 32'(order[4]), 32'd0);

    // Randomized traffic, including occasional resets and transmitter stalls.
    for (int c = 0; c < 3000; c++)
      applyStimulus(logic'($urandom_range(0, 499) != 0), 4'($urandom), $urandom,
                    16'($urandom), logic'($urandom_range(0, 9) < 7));
    applyStimulus(1, 4'b0000, 32'h0, 16'h0, 1);
    repeat (4) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 8: maximum cycles to wait in LAUNCH for tx_available to fall, range 2..255.
REQ-002 clk  in  1  UART bit clock, the same clock that drives the transmitter.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 req  in  4  per-requester transmit request, level; bit i belongs to requester i.
REQ-005 data  in  32  payload byte per requester; requester i uses bits [8i+7:8i].
REQ-006 cfg  in  16  frame config per requester; requester i uses bits [4i+3:4i] = {d_num, s_num, par[1:0]}.
REQ-007 ack  out  4  one-cycle completion pulse to the served requester.
REQ-008 grant_id  out  2  index of the requester currently owning the transmitter.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 err  out  1  one-cycle pulse on LAUNCH timeout.
REQ-011 tx_flag  out  1  start-send strobe to the transmitter.
REQ-012 tx_data  out  8  byte to the transmitter.
REQ-013 tx_d_num, tx_s_num  out  1 each  data-length and stop-count selects to the transmitter.
REQ-014 tx_par  out  2  parity select to the transmitter.
REQ-015 tx_available  in  1  transmitter line-available status.

Function
REQ-016 FSM states: IDLE, LAUNCH, BUSY, DONE; all outputs are registered.
REQ-017 IDLE: when tx_available=1 and req!=0, select the winner by round-robin, latch its data/cfg slice onto tx_data/tx_d_num/tx_s_num/tx_par, set grant_id, assert tx_flag, clear the timeout counter, and go to LAUNCH.
REQ-018 Round-robin order: search starts at (last_grant+1) mod 4 and wraps; last_grant updates only on grant.
REQ-019 IDLE with tx_available=0 or req=0: no grant; tx_flag=0.
REQ-020 LAUNCH: hold tx_flag=1 and the latched tx_* values; on tx_available=0, drop tx_flag and go to BUSY.
REQ-021 LAUNCH timeout: if tx_available is still 1 after TIMEOUT cycles in LAUNCH, drop tx_flag, pulse err for 1 cycle, pulse no ack, and return to IDLE. last_grant keeps the timed-out index.
REQ-022 BUSY: tx_flag=0 and tx_* held stable; on tx_available=1, go to DONE.
REQ-023 DONE: pulse ack[grant_id] for exactly 1 cycle, then go to IDLE. The earliest next grant is the following cycle.
REQ-024 tx_data/cfg are latched once per grant; requester changes to data/cfg/req after grant do not affect the frame in flight.
REQ-025 Deasserting req[i] while i is granted does not abort the frame; ack is still issued.
REQ-026 Requester i keeps req high until ack[i]; req still high in the cycle after ack counts as a new request.
REQ-027 At most one ack bit is set in any cycle; ack and err are never high together.
REQ-028 Each winning requester reaches BUSY at most 1+TIMEOUT cycles after grant.

Reset
REQ-029 rst=0 at a clock edge: state=IDLE, last_grant=3, ack=0, err=0, busy=0, grant_id=0, tx_flag=0, tx_data=0, tx_d_num=1, tx_s_num=1, tx_par=0.
REQ-030 Reset mid-frame abandons the frame without an ack. The transmitter is reset by the same rst.

Verification
REQ-031 Single req[2]=1, data byte2=0xA5, cfg2=4'b1110, tx_available=1 -> next cycle tx_flag=1, tx_data=0xA5, tx_d_num=1, tx_s_num=1, tx_par=2'b10, grant_id=2; ack[2] pulses once after tx_available returns to 1.
REQ-032 req=4'b1111 held continuously after reset -> grant order 0,1,2,3,0; each ack is one cycle with no overlap.
REQ-033 req[1]=1 and tx_available stuck at 1 -> err pulses exactly TIMEOUT cycles after LAUNCH entry; no ack; tx_flag=0 afterwards.
REQ-034 Grant requester 0, then change data/cfg byte0 and drop req[0] during BUSY -> tx_* unchanged until DONE; ack[0] still pulses.
REQ-035 rst=0 asserted during BUSY -> next cycle all outputs at reset values and no ack ever issued for that frame.
REQ-036 Back-to-back frames on a real transmitter with 2 stop bits and 7-bit odd parity -> the serial line shows correct frames and no lost or duplicated request.
